// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if -- signal bundle between the frame-buffer pixel writer,
// its upstream pixel sequencer / scan-out reader, and the frame-buffer RAM.
//   pix_*   : pixel stream (valid/ready handshake, X, Y, 12-bit colour)
//   rd_*    : scan-out read request and returned colour
//   ram_*   : single-port synchronous-read RAM port
// Modports: slave = the writer itself, master = the surrounding system.
interface fb_pixel_writer_if #(
    parameter int ADDR_W = 15
);
    logic              pix_valid;
    logic [7:0]        pix_x;
    logic [7:0]        pix_y;
    logic [11:0]       pix_color;
    logic              pix_ready;
    logic              rd_req;
    logic [7:0]        rd_x;
    logic [7:0]        rd_y;
    logic              rd_valid;
    logic [11:0]       rd_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [11:0]       ram_wdata;
    logic [11:0]       ram_rdata;

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color,
        output pix_ready,
        input  rd_req, rd_x, rd_y,
        output rd_valid, rd_data,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output pix_valid, pix_x, pix_y, pix_color,
        input  pix_ready,
        output rd_req, rd_x, rd_y,
        input  rd_valid, rd_data,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer -- commits a pixel stream into a single-port frame-buffer
// RAM through a small write FIFO, sharing the RAM port with scan-out reads.
// Reads always win the port; writes drain whenever no read is requested.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fb_pixel_writer_if.slave (pixel stream, read path, RAM port)
//   idle       : FIFO empty and no write issued this cycle
//   drop_cnt   : saturating count of out-of-range pixels rejected
// Optional feature: define FB_WRITE_DEDUP_EN to drop a pixel identical
// (address and colour) to the most recently enqueued one.
module fb_pixel_writer #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fb_pixel_writer_if.slave           bus,
    output logic                       idle,
    output logic [7:0]                 drop_cnt
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RD_STAGES = 2;

    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [11:0]       fifo_color [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] pix_addr, rd_addr;
    logic              pix_in_range, rd_in_range;
    logic              push_hs, enq, do_write, dup;

    logic [RD_STAGES:1] vld_pipe;
    logic [RD_STAGES:1] oor_pipe;

    assign pix_addr = ADDR_W'(bus.pix_y) * ADDR_W'(H_RES) + ADDR_W'(bus.pix_x);
    assign rd_addr  = ADDR_W'(bus.rd_y)  * ADDR_W'(H_RES) + ADDR_W'(bus.rd_x);

    assign pix_in_range = (32'(bus.pix_x) < H_RES) && (32'(bus.pix_y) < V_RES);
    assign rd_in_range  = (32'(bus.rd_x)  < H_RES) && (32'(bus.rd_y)  < V_RES);

    // Ready looks only at the registered count, so a same-cycle pop never
    // reopens a full FIFO.
    assign bus.pix_ready = (count < CNT_W'(FIFO_DEPTH));
    assign push_hs       = bus.pix_valid && bus.pix_ready;
    assign enq           = push_hs && pix_in_range && !dup;

    assign do_write = !bus.rd_req && (count != '0);
    assign idle     = (count == '0) && !do_write;

`ifdef FB_WRITE_DEDUP_EN
    logic              hist_vld;
    logic [ADDR_W-1:0] hist_addr;
    logic [11:0]       hist_color;

    assign dup = hist_vld && (hist_addr == pix_addr) && (hist_color == bus.pix_color);

    // History tracks the last pixel that actually entered the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_vld   <= 1'b0;
            hist_addr  <= '0;
            hist_color <= '0;
        end else if (enq) begin
            hist_vld   <= 1'b1;
            hist_addr  <= pix_addr;
            hist_color <= bus.pix_color;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Storage has no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr]  <= pix_addr;
            fifo_color[wr_ptr] <= bus.pix_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (enq)      wr_ptr <= wr_ptr + 1'b1;
            if (do_write) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, do_write})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_hs && !pix_in_range && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // RAM port: reads take the port, else drain the FIFO head, else hold addr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
        end else begin
            bus.ram_we <= do_write;
            if (bus.rd_req) begin
                bus.ram_addr <= rd_addr;
            end else if (do_write) begin
                bus.ram_addr  <= fifo_addr[rd_ptr];
                bus.ram_wdata <= fifo_color[rd_ptr];
            end
        end
    end

    // Read return: one stage for the address register, one for RAM latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            oor_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_STAGES-1:1], bus.rd_req};
            oor_pipe <= {oor_pipe[RD_STAGES-1:1], !rd_in_range};
        end
    end

    assign bus.rd_valid = vld_pipe[RD_STAGES];
    assign bus.rd_data  = (vld_pipe[RD_STAGES] && !oor_pipe[RD_STAGES]) ? bus.ram_rdata : 12'h000;
endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       idle;
    logic [7:0] drop_cnt;
    int         total = 0;
    int         bad   = 0;
    int         writes;

    logic [11:0] mem [1 << 15];

    fb_pixel_writer_if #(.ADDR_W(15)) bus ();

    fb_pixel_writer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .idle     (idle),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port RAM model.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic v, input int x, input int y, input int c);
        bus.pix_valid = v;
        bus.pix_x     = 8'(x);
        bus.pix_y     = 8'(y);
        bus.pix_color = 12'(c);
    endtask

    initial begin
        for (int i = 0; i < (1 << 15); i++) mem[i] = 12'h000;
        mem[170] = 12'h0AB;
        mem[200] = 12'h555;
        bus.ram_rdata = 12'h000;
        rst_n = 1'b0;
        set_pix(1'b0, 0, 0, 0);
        bus.rd_req = 1'b0;
        bus.rd_x   = 8'd0;
        bus.rd_y   = 8'd0;
        step();
        step();
        chk("rst_ready", 32'(bus.pix_ready), 1);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_we", 32'(bus.ram_we), 0);
        chk("rst_addr", 32'(bus.ram_addr), 0);
        chk("rst_rdvalid", 32'(bus.rd_valid), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst_n = 1'b1;

        // Single pixel write: (3,2) -> 2*160+3 = 323
        set_pix(1'b1, 3, 2, 12'hF00);
        step();
        set_pix(1'b0, 0, 0, 0);
        chk("w1_idle_busy", 32'(idle), 0);
        step();
        chk("w1_we", 32'(bus.ram_we), 1);
        chk("w1_addr", 32'(bus.ram_addr), 323);
        chk("w1_wdata", 32'(bus.ram_wdata), 12'hF00);
        chk("w1_idle", 32'(idle), 1);
        step();
        chk("w1_we_off", 32'(bus.ram_we), 0);

        // Reads block writes; FIFO fills at 4
        bus.rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_pix(1'b1, i, 10, i + 1);
            chk("fill_ready", 32'(bus.pix_ready), (i < 4) ? 1 : 0);
            chk("fill_we", 32'(bus.ram_we), 0);
            step();
        end
        set_pix(1'b0, 0, 0, 0);
        chk("full_ready", 32'(bus.pix_ready), 0);
        chk("full_we", 32'(bus.ram_we), 0);
        step();
        chk("full_we2", 32'(bus.ram_we), 0);
        bus.rd_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("drain_we", 32'(bus.ram_we), 1);
            chk("drain_addr", 32'(bus.ram_addr), 1600 + j);
            chk("drain_wdata", 32'(bus.ram_wdata), j + 1);
        end
        step();
        chk("drain_done_we", 32'(bus.ram_we), 0);
        chk("drain_idle", 32'(idle), 1);
        step();
        step();

        // Read (10,1) -> addr 170, data returns two cycles after request
        bus.rd_req = 1'b1; bus.rd_x = 8'd10; bus.rd_y = 8'd1;
        step();
        bus.rd_req = 1'b0;
        chk("rd_addr", 32'(bus.ram_addr), 170);
        chk("rd_we", 32'(bus.ram_we), 0);
        chk("rd_early", 32'(bus.rd_valid), 0);
        step();
        chk("rd_valid", 32'(bus.rd_valid), 1);
        chk("rd_data", 32'(bus.rd_data), 12'h0AB);
        step();
        chk("rd_valid_off", 32'(bus.rd_valid), 0);

        // Corner read (159,119) -> 19199
        bus.rd_req = 1'b1; bus.rd_x = 8'd159; bus.rd_y = 8'd119;
        step();
        bus.rd_req = 1'b0;
        chk("rd_corner_addr", 32'(bus.ram_addr), 19199);
        step();
        step();

        // Out-of-range read (200,0): valid but data forced to 0
        bus.rd_req = 1'b1; bus.rd_x = 8'd200; bus.rd_y = 8'd0;
        step();
        bus.rd_req = 1'b0;
        chk("rd_oor_addr", 32'(bus.ram_addr), 200);
        step();
        chk("rd_oor_valid", 32'(bus.rd_valid), 1);
        chk("rd_oor_data", 32'(bus.rd_data), 0);
        step();

        // Range drops
        set_pix(1'b1, 160, 0, 12'h123);
        step();
        set_pix(1'b0, 0, 0, 0);
        chk("drop_x", 32'(drop_cnt), 1);
        chk("drop_x_idle", 32'(idle), 1);
        step();
        chk("drop_x_we", 32'(bus.ram_we), 0);
        set_pix(1'b1, 0, 120, 12'h123);
        step();
        set_pix(1'b0, 0, 0, 0);
        chk("drop_y", 32'(drop_cnt), 2);
        for (int i = 0; i < 300; i++) begin
            set_pix(1'b1, 200, 200, 12'h321);
            step();
        end
        set_pix(1'b0, 0, 0, 0);
        chk("drop_sat", 32'(drop_cnt), 255);
        chk("drop_sat_idle", 32'(idle), 1);
        step();
        chk("drop_sat_we", 32'(bus.ram_we), 0);

        // Reset with 3 pending entries
        bus.rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_pix(1'b1, i, 1, 12'hABC);
            step();
        end
        set_pix(1'b0, 0, 0, 0);
        chk("pre_rst_idle", 32'(idle), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.rd_req = 1'b0;
        chk("mid_rst_idle", 32'(idle), 1);
        chk("mid_rst_ready", 32'(bus.pix_ready), 1);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        chk("mid_rst_addr", 32'(bus.ram_addr), 0);
        chk("mid_rst_we", 32'(bus.ram_we), 0);
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.ram_we) writes++;
        end
        chk("post_rst_writes", 32'(writes), 0);

        // Repeated identical pixel (5,5) -> addr 805
        writes = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 3) set_pix(1'b1, 5, 5, 12'h0F0);
            else       set_pix(1'b0, 0, 0, 0);
            step();
            if (bus.ram_we) begin
                writes++;
                chk("dup_addr", 32'(bus.ram_addr), 805);
            end
        end
`ifdef FB_WRITE_DEDUP_EN
        chk("dup_writes", 32'(writes), 1);
`else
        chk("dup_writes", 32'(writes), 3);
`endif
        chk("dup_drop", 32'(drop_cnt), 0);
        chk("end_idle", 32'(idle), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
